id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the RISC-V core.
- Buffers decoded instructions in a 2-entry skid buffer (main + skid) with valid/ready handshakes on both sides.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages, then drives the A/B/ALUop inputs of the combinational ALU directly.
- Supports pipeline flush on branch redirect.

Parameters:
- XLEN, 32, datapath width (ALU operand/result width).
- RA_W, 5, register address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill all buffered entries and the same-cycle incoming instruction.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_pc  in  XLEN  instruction PC.
- in_rs1_data / in_rs2_data  in  XLEN  register file read data; regfile is write-first.
- in_rs1_addr / in_rs2_addr / in_rd_addr  in  RA_W  source/destination register indices.
- in_imm  in  XLEN  sign-extended immediate.
- in_alu_op  in  3  ALU operation code: 000 ADD, 010 SUB, 110 AND, 100 XOR, 001 SLL, 011 SRL.
- in_alu_src_imm  in  1  1: ALU B = immediate.
- in_reg_write / in_mem_read / in_mem_write / in_branch  in  1  control bits.
- ex_fwd_valid  in  1  EX/MEM holds a reg-writing result.
- ex_fwd_rd  in  RA_W  EX/MEM destination register.
- ex_fwd_data  in  XLEN  EX/MEM result.
- wb_fwd_valid  in  1  MEM/WB is writing the register file this cycle.
- wb_fwd_rd  in  RA_W  MEM/WB destination register.
- wb_fwd_data  in  XLEN  MEM/WB write data.
- out_valid  out  1  main entry valid.
- out_ready  in  1  execute stage accepts.
- alu_a / alu_b  out  XLEN  forwarded ALU operands.
- alu_op  out  3  ALU operation code.
- store_data  out  XLEN  forwarded rs2 value.
- out_pc  out  XLEN  PC of the main entry.
- out_rd_addr  out  RA_W  destination register of the main entry.
- out_reg_write / out_mem_read / out_mem_write / out_branch  out  1  control bits of the main entry.

Behaviour:
- Reset (async, rst_n=0):
  - main_valid=0, skid_valid=0.
  - All stored fields 0, so every data/control output is 0.
  - in_ready=1 once reset is released.
- Accept: in_valid && in_ready.
  - Main empty, or main leaving (out_ready=1): load into main.
  - Main held (out_valid && !out_ready): load into skid; in_ready=0 the next cycle.
- Drain: when out_valid && out_ready and skid_valid, skid moves to main and skid_valid clears. A new accept that same cycle is impossible because in_ready=0.
- Throughput: one instruction per cycle; zero bubbles while out_ready=1. Latency in_valid to out_valid = 1 cycle.
- Flush:
  - Highest priority. Next edge: main_valid=0, skid_valid=0; the incoming instruction is dropped.
  - in_ready=1 the following cycle.
  - Stored data is don't-care; control outputs are gated by valid (out_reg_write, out_mem_write, etc. read 0 when !out_valid).
- Forwarding, combinational on the main entry, per source operand:
  - Priority: EX match > WB match > stored value.
  - A match requires fwd_valid, equal address, and address != 0.
  - x0 always reads 0.
  - alu_a = forwarded rs1.
  - alu_b = in_alu_src_imm ? imm : forwarded rs2.
  - store_data = forwarded rs2, regardless of alu_src_imm.
- Held refresh:
  - At every edge where an entry is retained (main held, or skid occupied), each of its rs1/rs2 fields whose address matches a WB write (rd != 0) is overwritten with wb_fwd_data. This prevents a retiring producer from being lost.
  - EX values are never captured. EX/MEM is stalled together with this stage, and a younger EX writer still overrides at the output.
- Incoming data is captured without forwarding; the write-first regfile covers same-cycle WB.
- Output stability: while out_valid && !out_ready, out_pc, alu_op, rd and control bits are stable. alu_a/alu_b/store_data change only by forwarding.

Optional Feature:
- ID_EX_FWD_EN defined: forwarding mux and held refresh as described.
- Undefined:
  - ex_fwd_* and wb_fwd_* are ignored.
  - alu_a = stored rs1, alu_b = imm or stored rs2, store_data = stored rs2.
  - Hazards must be handled by stalling in decode.

Test Plan:
- Reset mid-stream: two entries buffered, pulse rst_n low -> out_valid=0, all outputs 0 immediately; in_ready=1 after release.
- Back-to-back: 4 ADD instructions with out_ready=1 continuously -> out_valid from cycle 1, one per cycle, in order, in_ready stays 1.
- Skid: out_ready=0 while 2 instructions arrive -> second goes to skid, in_ready=0. Raise out_ready -> PCs 0x100 then 0x104 in order, no loss, no duplication.
- Forward priority: main rs1=x5, stored 0x11; ex_fwd x5=0x22 and wb_fwd x5=0x33 -> alu_a=0x22. Drop ex_fwd_valid -> alu_a=0x33. Use rs1=x0 with both sources on rd=0 -> alu_a=0.
- Held refresh: main stalled with rs2=x7 stored 0x1, alu_src_imm=0; one-cycle wb_fwd x7=0xABCD; then out_ready=1 -> alu_b=0xABCD and store_data=0xABCD in the accept cycle.
- Flush: main+skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, out_reg_write=0, in_ready=1; the dropped instruction never appears.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline stage.
// Two-entry skid buffer (main + skid) with valid/ready handshakes on both sides.
// Operand forwarding from EX/MEM and MEM/WB feeds the combinational ALU inputs.
// A branch-redirect flush kills both entries and the same-cycle incoming instruction.
// Optional feature macro: ID_EX_FWD_EN enables the forwarding mux and the
// refresh of held entries from MEM/WB. When the macro is undefined, the
// forwarding inputs are ignored and decode must stall on hazards.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_alu_op,
    input  logic            in_alu_src_imm,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic            in_branch,
    input  logic            ex_fwd_valid,
    input  logic [RA_W-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            wb_fwd_valid,
    input  logic [RA_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] out_pc,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
        logic [2:0]      alu_op;
        logic            alu_src_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
    } entry_t;

    entry_t          main_q;
    entry_t          skid_q;
    entry_t          in_entry;
    entry_t          main_keep;
    entry_t          skid_keep;
    logic            main_valid;
    logic            skid_valid;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // A forwarding source matches only a real write to a non-zero register.
    function automatic logic addr_match(input logic            v,
                                        input logic [RA_W-1:0] rd,
                                        input logic [RA_W-1:0] a);
        return v && (rd != '0) && (rd == a);
    endfunction

    // Pack the decode-side fields; incoming data is captured unforwarded
    // because the write-first register file already covers same-cycle WB.
    always_comb begin
        in_entry             = '0;
        in_entry.pc          = in_pc;
        in_entry.rs1_data    = in_rs1_data;
        in_entry.rs2_data    = in_rs2_data;
        in_entry.imm         = in_imm;
        in_entry.rs1_addr    = in_rs1_addr;
        in_entry.rs2_addr    = in_rs2_addr;
        in_entry.rd_addr     = in_rd_addr;
        in_entry.alu_op      = in_alu_op;
        in_entry.alu_src_imm = in_alu_src_imm;
        in_entry.reg_write   = in_reg_write;
        in_entry.mem_read    = in_mem_read;
        in_entry.mem_write   = in_mem_write;
        in_entry.branch      = in_branch;
    end

    // Retained entries absorb a retiring MEM/WB write so the producer's
    // value is not lost once it leaves the forwarding network.
    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        main_keep = main_q;
        skid_keep = skid_q;
`ifdef ID_EX_FWD_EN
        if (addr_match(wb_fwd_valid, wb_fwd_rd, main_q.rs1_addr)) main_keep.rs1_data = wb_fwd_data;
        if (addr_match(wb_fwd_valid, wb_fwd_rd, main_q.rs2_addr)) main_keep.rs2_data = wb_fwd_data;
        if (addr_match(wb_fwd_valid, wb_fwd_rd, skid_q.rs1_addr)) skid_keep.rs1_data = wb_fwd_data;
        if (addr_match(wb_fwd_valid, wb_fwd_rd, skid_q.rs2_addr)) skid_keep.rs2_data = wb_fwd_data;
`endif
    end

    // Skid buffer: flush wins, then skid drains into main, else main loads or holds.
    // NOTE: the stored fields are reset as well, so every output reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so no new instruction can arrive.
            if (out_ready) begin
                main_q     <= skid_keep;
                skid_valid <= 1'b0;
            end else begin
                main_q <= main_keep;
                skid_q <= skid_keep;
            end
        end else if (!main_valid || out_ready) begin
            main_valid <= in_valid;
            if (in_valid) begin
                main_q <= in_entry;
            end
        end else begin
            main_q <= main_keep;
            if (in_valid) begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end
    end

    // Source operand selection for the main entry: EX beats WB beats stored; x0 is 0.
    always_comb begin
        rs1_val = main_q.rs1_data;
        rs2_val = main_q.rs2_data;
`ifdef ID_EX_FWD_EN
        if (main_q.rs1_addr == '0)                                  rs1_val = '0;
        else if (addr_match(ex_fwd_valid, ex_fwd_rd, main_q.rs1_addr)) rs1_val = ex_fwd_data;
        else if (addr_match(wb_fwd_valid, wb_fwd_rd, main_q.rs1_addr)) rs1_val = wb_fwd_data;
        if (main_q.rs2_addr == '0)                                  rs2_val = '0;
        else if (addr_match(ex_fwd_valid, ex_fwd_rd, main_q.rs2_addr)) rs2_val = ex_fwd_data;
        else if (addr_match(wb_fwd_valid, wb_fwd_rd, main_q.rs2_addr)) rs2_val = wb_fwd_data;
`endif
    end

`ifndef ID_EX_FWD_EN
    // Forwarding inputs and source addresses are intentionally unused in this build.
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                          wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
                          main_q.rs1_addr, main_q.rs2_addr};
`endif

    assign in_ready      = !skid_valid;
    assign out_valid     = main_valid;
    assign alu_a         = rs1_val;
    assign alu_b         = main_q.alu_src_imm ? main_q.imm : rs2_val;
    assign store_data    = rs2_val;
    assign alu_op        = main_q.alu_op;
    assign out_pc        = main_q.pc;
    assign out_rd_addr   = main_q.rd_addr;
    assign out_reg_write = main_valid && main_q.reg_write;
    assign out_mem_read  = main_valid && main_q.mem_read;
    assign out_mem_write = main_valid && main_q.mem_write;
    assign out_branch    = main_valid && main_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, back-to-back flow, skid ordering,
// forwarding priority, held-entry refresh, flush and mid-stream reset.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [2:0]  in_alu_op;
    logic        in_alu_src_imm, in_reg_write, in_mem_read, in_mem_write, in_branch;
    logic        ex_fwd_valid, wb_fwd_valid;
    logic [4:0]  ex_fwd_rd, wb_fwd_rd;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, store_data, out_pc;
    logic [2:0]  alu_op;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_imm(in_imm), .in_alu_op(in_alu_op), .in_alu_src_imm(in_alu_src_imm),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_branch(in_branch),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
        .out_pc(out_pc), .out_rd_addr(out_rd_addr),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_branch(out_branch)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction on the decode side; ctrl = {reg_write, mem_read, mem_write, branch}.
    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                             input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [4:0] rd,
                             input logic [31:0] imm, input logic [2:0] op, input logic src_imm,
                             input logic [3:0] ctrl);
        in_pc = pc; in_rs1_addr = rs1a; in_rs1_data = rs1d;
        in_rs2_addr = rs2a; in_rs2_data = rs2d; in_rd_addr = rd;
        in_imm = imm; in_alu_op = op; in_alu_src_imm = src_imm;
        {in_reg_write, in_mem_read, in_mem_write, in_branch} = ctrl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        n_tests++; if ({alu_a, alu_b, store_data} !== 96'h0) begin n_fail++; $display("FAIL reset_operands: got %h %h %h want 0", alu_a, alu_b, store_data); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(32'h200 + 32'(4 * i), 5'd1, 32'h10 + 32'(i), 5'd2, 32'h20 + 32'(i),
                      5'(i + 3), 32'h0, 3'b000, 1'b0, 4'b1000);
            in_valid = 1'b1;
            tick();
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            n_tests++; if (out_pc !== 32'h200 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, out_pc, 32'h200 + 32'(4 * i)); end
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
            n_tests++; if (alu_a !== 32'h10 + 32'(i) || alu_b !== 32'h20 + 32'(i)) begin n_fail++; $display("FAIL b2b_operands[%0d]: got %h %h want %h %h", i, alu_a, alu_b, 32'h10 + 32'(i), 32'h20 + 32'(i)); end
            n_tests++; if (out_rd_addr !== 5'(i + 3) || out_reg_write !== 1'b1) begin n_fail++; $display("FAIL b2b_rd[%0d]: got %0d/%b want %0d/1", i, out_rd_addr, out_reg_write, i + 3); end
        end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        set_instr(32'h100, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 3'b010, 1'b0, 4'b1000);
        in_valid = 1'b1;
        tick();
        n_tests++; if (out_pc !== 32'h100 || in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_first: got pc %h rdy %b want 100/1", out_pc, in_ready); end
        set_instr(32'h104, 5'd4, 32'h4, 5'd5, 32'h5, 5'd6, 32'h0, 3'b110, 1'b0, 4'b1000);
        tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready: got %b want 0", in_ready); end
        n_tests++; if (out_pc !== 32'h100 || alu_op !== 3'b010) begin n_fail++; $display("FAIL skid_main_stable: got %h/%b want 100/010", out_pc, alu_op); end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_pc !== 32'h100 || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_held: got %h/%b want 100/1", out_pc, out_valid); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_pc !== 32'h104 || out_valid !== 1'b1 || alu_op !== 3'b110) begin n_fail++; $display("FAIL skid_second: got %h/%b/%b want 104/1/110", out_pc, out_valid, alu_op); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_drained_ready: got %b want 1", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_fwd_priority();
        out_ready = 1'b0;
        set_instr(32'h300, 5'd5, 32'h11, 5'd6, 32'h66, 5'd9, 32'h44, 3'b000, 1'b1, 4'b1000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_data = 32'h22;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h33;
        #1;
        n_tests++; if (alu_a !== (FWD ? 32'h22 : 32'h11)) begin n_fail++; $display("FAIL fwd_ex_over_wb: got %h want %h", alu_a, FWD ? 32'h22 : 32'h11); end
        n_tests++; if (alu_b !== 32'h44 || store_data !== 32'h66) begin n_fail++; $display("FAIL fwd_imm_store: got %h/%h want 44/66", alu_b, store_data); end
        ex_fwd_valid = 1'b0;
        #1;
        n_tests++; if (alu_a !== (FWD ? 32'h33 : 32'h11)) begin n_fail++; $display("FAIL fwd_wb: got %h want %h", alu_a, FWD ? 32'h33 : 32'h11); end
        wb_fwd_valid = 1'b0;
        out_ready = 1'b1;
        set_instr(32'h304, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h7f, 3'b100, 1'b1, 4'b1000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'h22;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h33;
        #1;
        n_tests++; if (out_pc !== 32'h304 || alu_a !== 32'h0 || store_data !== 32'h0) begin n_fail++; $display("FAIL fwd_x0: got pc %h a %h sd %h want 304/0/0", out_pc, alu_a, store_data); end
        n_tests++; if (alu_b !== 32'h7f) begin n_fail++; $display("FAIL fwd_x0_imm: got %h want 7f", alu_b); end
        ex_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_held_refresh();
        out_ready = 1'b0;
        set_instr(32'h400, 5'd8, 32'h5, 5'd7, 32'h1, 5'd0, 32'h0, 3'b000, 1'b0, 4'b0010);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hABCD;
        tick();
        wb_fwd_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        n_tests++; if (alu_b !== (FWD ? 32'hABCD : 32'h1)) begin n_fail++; $display("FAIL refresh_alu_b: got %h want %h", alu_b, FWD ? 32'hABCD : 32'h1); end
        n_tests++; if (store_data !== (FWD ? 32'hABCD : 32'h1)) begin n_fail++; $display("FAIL refresh_store: got %h want %h", store_data, FWD ? 32'hABCD : 32'h1); end
        n_tests++; if (alu_a !== 32'h5 || out_mem_write !== 1'b1) begin n_fail++; $display("FAIL refresh_other: got %h/%b want 5/1", alu_a, out_mem_write); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || out_mem_write !== 1'b0) begin n_fail++; $display("FAIL refresh_drain: got %b/%b want 0/0", out_valid, out_mem_write); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_instr(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 3'b000, 1'b0, 4'b1000);
        in_valid = 1'b1;
        tick();
        set_instr(32'h504, 5'd1, 32'h1, 5'd2, 32'h2, 5'd4, 32'h0, 3'b000, 1'b0, 4'b1000);
        tick();
        n_tests++; if (in_ready !== 1'b0 || out_pc !== 32'h500) begin n_fail++; $display("FAIL flush_full: got rdy %b pc %h want 0/500", in_ready, out_pc); end
        set_instr(32'h508, 5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 32'h0, 3'b000, 1'b0, 4'b1000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state: got v %b rw %b rdy %b want 0/0/1", out_valid, out_reg_write, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got out_valid %b pc %h want 0", i, out_valid, out_pc); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        set_instr(32'h600, 5'd1, 32'h123, 5'd2, 32'h456, 5'd7, 32'h99, 3'b010, 1'b0, 4'b1101);
        in_valid = 1'b1;
        tick();
        set_instr(32'h604, 5'd3, 32'h789, 5'd4, 32'habc, 5'd8, 32'h98, 3'b011, 1'b1, 4'b1111);
        tick();
        in_valid = 1'b0;
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_full: got rdy %b v %b want 0/1", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_tests++; if ({out_pc, alu_a, alu_b, store_data} !== 128'h0) begin n_fail++; $display("FAIL midrst_data: got %h %h %h %h want 0", out_pc, alu_a, alu_b, store_data); end
        n_tests++; if ({alu_op, out_rd_addr, out_reg_write, out_mem_read, out_mem_write, out_branch} !== 12'h0) begin n_fail++; $display("FAIL midrst_ctrl: got %b %0d %b%b%b%b want 0", alu_op, out_rd_addr, out_reg_write, out_mem_read, out_mem_write, out_branch); end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_replay: got %b want 0", out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_instr(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 3'b000, 1'b0, 4'b0000);
        ex_fwd_valid = 1'b0; ex_fwd_rd = 5'd0; ex_fwd_data = 32'h0;
        wb_fwd_valid = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h0;
        test_reset();
        test_back_to_back();
        test_skid();
        test_fwd_priority();
        test_held_refresh();
        test_flush();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
